// File: rtl/pcie_fifo.sv
// pcie_fifo: synchronous FIFO buffering lane symbols ahead of one input
// of the 2:1 output mux. The read data is registered, and valid_out marks
// a symbol that was popped on the previous edge. The full, empty,
// almost-full and almost-empty flags are decoded from the registered
// occupancy count.
// Optional feature: define PCIE_FIFO_ERROR_EN to build a sticky
// overflow/underflow flag on fifo_error. Without it, fifo_error is tied to 0.
module pcie_fifo #(
    parameter int DATA_WIDTH       = 10,
    parameter int ADDR_WIDTH       = 2,
    parameter int ALMOST_FULL_LVL  = 3,
    parameter int ALMOST_EMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_LVL_C = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0] AE_LVL_C = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    logic                  full, empty;
    logic                  wr_en, rd_en;

    // Flags depend only on the registered occupancy.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A read is accepted whenever data is stored. A write is accepted when
    // there is room. When full, a write is also accepted if a read frees
    // the oldest slot on the same edge. On empty there is no fall-through:
    // a simultaneous pop is an underflow, not a read of the new data.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || pop);

    // Compute the next pointer, count and read-data state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = mem[rd_ptr_q];
            valid_out_d = 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // Control and output registers are cleared asynchronously. The
    // storage array is not cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Write the accepted symbol into the storage array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef PCIE_FIFO_ERROR_EN
    logic error_q, error_d;
    logic overflow, underflow;

    // A push on full is an overflow only when no pop frees a slot.
    assign overflow  = push && full && !pop;
    assign underflow = pop && empty;

    // Once an overflow or underflow is seen, the error flag stays set
    // until reset.
    always_comb begin
        error_d = error_q | overflow | underflow;
    end

    // Register the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign fifo_error = error_q;
`else
    assign fifo_error = 1'b0;
`endif

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign almost_full  = (count_q >= AF_LVL_C);
    assign almost_empty = (count_q <= AE_LVL_C);

endmodule

// File: tb/tb_pcie_fifo.sv
// Directed testbench for pcie_fifo. A queue model tracks the FIFO
// contents. Each accepted read pushes its expected symbol onto a
// scoreboard queue. When the DUT presents valid_out, the bench pops the
// scoreboard and compares the entry against data_out.
module tb_pcie_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic [9:0] data_in;
    logic       pop;
    logic [9:0] data_out;
    logic       valid_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_error;

    logic [9:0] model [$];
    logic [9:0] sb [$];
    logic [9:0] exp_dout;
    logic       err_m;
    int         n_chk;
    int         n_err;

    pcie_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop a hung run with a FAIL line before the simulation limit is reached.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_error();
`ifdef PCIE_FIFO_ERROR_EN
        return err_m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_flags(input string tag);
        int n;
        n = model.size();
        chk({tag, ".full"},   32'(fifo_full),    32'(n == 4));
        chk({tag, ".empty"},  32'(fifo_empty),   32'(n == 0));
        chk({tag, ".afull"},  32'(almost_full),  32'(n >= 3));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
        chk({tag, ".error"},  32'(fifo_error),   32'(exp_error()));
    endtask

    // Drive one cycle of push/pop, update the model, and check after the edge.
    task automatic step(input logic p, input logic [9:0] d, input logic r, input string tag);
        logic full_m, empty_m, rd, wr;
        @(negedge clk);
        push    = p;
        data_in = d;
        pop     = r;
        full_m  = (model.size() == 4);
        empty_m = (model.size() == 0);
        rd = r && !empty_m;
        wr = p && (!full_m || r);
        if ((p && full_m && !r) || (r && empty_m)) err_m = 1'b1;
        if (rd) begin
            exp_dout = model.pop_front();
            sb.push_back(exp_dout);
        end
        if (wr) model.push_back(d);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(valid_out), 32'(rd));
        if (rd) begin
            chk({tag, ".data"}, 32'(data_out), 32'(sb.pop_front()));
        end else begin
            chk({tag, ".hold"}, 32'(data_out), 32'(exp_dout));
        end
        check_flags(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".valid"}, 32'(valid_out), 32'(0));
        chk({tag, ".data"},  32'(data_out),  32'(0));
        check_flags(tag);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        err_m    = 1'b0;
        exp_dout = '0;
        reset    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;

        #3;
        check_reset_state("rst0");
        @(negedge clk);
        reset = 1'b1;

        // Fill to full, then push while full without a pop.
        for (int i = 1; i <= 4; i++) step(1'b1, 10'(i), 1'b0, $sformatf("fill%0d", i));
        step(1'b1, 10'h2FF, 1'b0, "ovf");
        // Drain the four stored symbols in order.
        for (int i = 0; i < 4; i++) step(1'b0, 10'h0, 1'b1, $sformatf("drain%0d", i));
        // Pop on empty, then push and pop together on empty.
        step(1'b0, 10'h0, 1'b1, "unf");
        step(1'b1, 10'h0AA, 1'b1, "pp_empty");
        step(1'b0, 10'h0, 1'b1, "pop_aa");

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) step(1'b1, 10'(16 + i), 1'b0, $sformatf("f1x%0d", i));
        step(1'b1, 10'h020, 1'b1, "pp_full");
        for (int i = 0; i < 4; i++) step(1'b0, 10'h0, 1'b1, $sformatf("d1x%0d", i));

        // Interleave pushes and pops so both pointers wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 10'(10'h3A0 + i), (i > 0), $sformatf("wrap%0d", i));
        step(1'b0, 10'h0, 1'b1, "wrap_last");

        // Assert reset mid-stream with 3 entries stored and valid_out high.
        for (int i = 0; i < 4; i++) step(1'b1, 10'(10'h100 + i), 1'b0, $sformatf("pre%0d", i));
        step(1'b0, 10'h0, 1'b1, "pre_pop");
        #2;
        reset = 1'b0;
        model.delete();
        sb.delete();
        exp_dout = '0;
        err_m    = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        reset = 1'b1;
        step(1'b1, 10'h155, 1'b0, "post_push");
        step(1'b0, 10'h0, 1'b1, "post_pop");
        step(1'b0, 10'h0, 1'b0, "idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
